sync_debounce_edge: RTL
=======================

// Module: sync_debounce_edge
// PURPOSE
//   Per-channel conditioning for asynchronous inputs (buttons, switches, foreign-domain
//   levels). Each channel passes through a STAGES-deep flop synchronizer, then a
//   press debouncer driven by a shared sample tick, then an edge detector.
//   Sits between board pins and the user logic; supersedes the fixed 2-flop synchronizer.
// PARAMETERS
//   WIDTH           1      number of independent channels
//   STAGES          2      synchronizer depth in flops; legal range >= 2
//   SAMPLE_CNT_MAX  25000  clk cycles per debounce sample tick; legal range >= 1
//   PULSE_CNT_MAX   150    consecutive high samples required before debounced asserts; legal range >= 1
// PORTS
//   clk           in   1      system clock
//   rst           in   1      asynchronous, active-high reset
//   async_signal  in   WIDTH  raw asynchronous inputs
//   sync_signal   out  WIDTH  synchronized level, STAGES cycles latency
//   debounced     out  WIDTH  debounced level
//   rise_pulse    out  WIDTH  1-cycle pulse on debounced 0->1
//   fall_pulse    out  WIDTH  1-cycle pulse on debounced 1->0
// BEHAVIOUR
//   - Reset: every flop clears to 0 asynchronously on rst=1. While rst=1, all outputs are 0.
//     The sample counter restarts at 0 when rst deasserts.
//   - Sync chain: per channel, STAGES flops in series, no logic between them.
//     sync_signal[i] is the last flop. An input step appears after exactly STAGES rising edges.
//   - Sample tick:
//     - One free-running counter, shared by all channels.
//     - Counts 0..SAMPLE_CNT_MAX-1 and wraps to 0.
//     - tick = (count == SAMPLE_CNT_MAX-1). This is combinational from the counter
//       register, so tick is high for 1 cycle every SAMPLE_CNT_MAX cycles.
//   - Debounce counter: one per channel, width $clog2(PULSE_CNT_MAX+1), updated on each clk edge:
//     - sync_signal[i]==0 -> cnt <= 0. This takes priority over tick, so release is immediate.
//     - else if tick && cnt < PULSE_CNT_MAX -> cnt <= cnt+1.
//     - else hold. The counter saturates at PULSE_CNT_MAX and never wraps.
//   - debounced[i] = (cnt[i] == PULSE_CNT_MAX), decoded combinationally from the counter register.
//   - Only the press is filtered. Any low sample on sync_signal clears the channel.
//     A glitch shorter than PULSE_CNT_MAX ticks therefore never asserts debounced.
//   - Edge detect:
//     - prev[i] <= debounced[i] on each clk edge.
//     - rise_pulse = debounced & ~prev.
//     - fall_pulse = ~debounced & prev.
//     - Each pulse lasts exactly 1 cycle. rise and fall are never high together on one channel.
//   - Press latency: from sync_signal rising, debounced asserts after (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX+1
//     to PULSE_CNT_MAX*SAMPLE_CNT_MAX cycles, depending on tick phase.
//   - Release latency: debounced falls 1 cycle after sync_signal falls.
//   - Channels are fully independent apart from the shared tick.
//     Simultaneous presses on several channels are handled in parallel.
//   - Reset mid-operation:
//     - Counters and prev clear, and no fall_pulse is emitted.
//     - After rst deasserts, a held-high input re-debounces from zero and then gives one rise_pulse.
// STRUCTURE
//   - No shared package. Widths come from local $clog2 of the parameters.
//   - Parameter legality is checked with an initial-block $error in simulation.
//   - Sub-module edge_detector #(WIDTH): holds the prev register and drives rise_pulse/fall_pulse.
//   - Sync chain, tick counter and debounce counters stay in this module, generated per channel.
// TESTING  (WIDTH=2, STAGES=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3)
//   - Reset: hold rst for 3 cycles with async_signal=2'b11 -> all outputs 0 throughout.
//   - Sync latency: async_signal[0] steps 0->1 just after edge k.
//     -> sync_signal[0]=1 after edge k+2; channel 1 unaffected.
//   - Press: hold async_signal[0]=1.
//     -> debounced[0] asserts within 9..12 cycles of sync_signal[0] rising.
//     -> rise_pulse[0] is high exactly 1 cycle, coincident with that assertion.
//   - Bounce: pulse async_signal[0] high for 6 cycles, low for 1, high again.
//     -> debounced[0] does not assert until 3 fresh ticks after the low cycle clears.
//   - Release: drop async_signal[0] while debounced[0]=1.
//     -> debounced[0]=0 three edges later (2 sync + 1 counter clear).
//     -> fall_pulse[0] high 1 cycle.
//   - Reset mid-press and parallel channels:
//     - Assert rst with debounced=2'b11 and inputs held high.
//       -> outputs 0 immediately and no fall_pulse.
//     - After rst release -> both channels re-assert together, each with a single rise_pulse.

Source files
------------

// File: rtl/sync_debounce_edge_edge_detector.sv
// Registers the previous debounced level and flags 0->1 / 1->0 transitions
// as single-cycle pulses.
module edge_detector #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
        end else begin
            prev <= level;
        end
    end

    // Level and prev both clear on reset, so reset never produces a fall pulse.
    assign rise_pulse = level & ~prev;
    assign fall_pulse = ~level & prev;
endmodule

// File: rtl/sync_debounce_edge.sv
// Input conditioning for asynchronous pins: per-channel flop synchronizer,
// press-only debouncer on a shared sample tick, and edge pulses.
module sync_debounce_edge #(
    parameter int WIDTH          = 1,
    parameter int STAGES         = 2,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_signal,
    output logic [WIDTH-1:0] sync_signal,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);
    localparam int SAMPLE_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int PULSE_W  = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [PULSE_W-1:0]  PULSE_FULL  = PULSE_W'(PULSE_CNT_MAX);

`ifndef SYNTHESIS
    initial begin
        if (STAGES < 2)         $error("sync_debounce_edge: STAGES must be >= 2");
        if (SAMPLE_CNT_MAX < 1) $error("sync_debounce_edge: SAMPLE_CNT_MAX must be >= 1");
        if (PULSE_CNT_MAX < 1)  $error("sync_debounce_edge: PULSE_CNT_MAX must be >= 1");
        if (WIDTH < 1)          $error("sync_debounce_edge: WIDTH must be >= 1");
    end
`endif

    logic [SAMPLE_W-1:0] sample_cnt;
    logic                tick;

    // One free-running sample counter shared by every channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (tick) begin
            sample_cnt <= '0;
        end else begin
            sample_cnt <= sample_cnt + SAMPLE_W'(1);
        end
    end

    assign tick = (sample_cnt == SAMPLE_LAST);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic [STAGES-1:0]  chain;
        logic [PULSE_W-1:0] cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                chain <= '0;
            end else begin
                chain <= {chain[STAGES-2:0], async_signal[i]};
            end
        end

        assign sync_signal[i] = chain[STAGES-1];

        // A low sample wins over the tick, so release is immediate; press saturates.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (!chain[STAGES-1]) begin
                cnt <= '0;
            end else if (tick && (cnt < PULSE_FULL)) begin
                cnt <= cnt + PULSE_W'(1);
            end
        end

        assign debounced[i] = (cnt == PULSE_FULL);
    end

    edge_detector #(
        .WIDTH (WIDTH)
    ) u_edge (
        .clk        (clk),
        .rst        (rst),
        .level      (debounced),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );
endmodule
